buffer_reader: RTL
==================

Name: buffer_reader

Overview:
Read-side controller for the 8-entry dual-mode (FIFO/LIFO) buffer. On a start command it drains up to a requested number of entries by pulsing the buffer's read enable. Each word is presented on a valid/ready output stream. It sits between the buffer's read port and a downstream consumer. It never issues a read while the buffer reports empty.

Parameters:
DATA_W, 8, width of buffer data and output stream
CNT_W, 4, width of request length and delivered count; must hold DEPTH
DEPTH, 8, buffer capacity; req_len values above DEPTH are clamped to DEPTH
TIMEOUT_CYC, 16, stall limit in cycles (used only with the optional feature)

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle drain request; sampled only in IDLE
mode  in  1  0 = FIFO, 1 = LIFO; latched on accepted start
req_len  in  CNT_W  entries to read; 0 = read until empty
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at end of operation
short  out  1  valid with done: buffer emptied before req_len was reached
timeout  out  1  valid with done: operation aborted on stall (0 without feature)
rd_count  out  CNT_W  words accepted downstream in current/last operation
buf_en  out  1  buffer enable; high only in ISSUE
buf_rd  out  1  buffer read strobe; high only in ISSUE
buf_mode  out  1  latched mode, held constant while busy
buf_data  in  DATA_W  buffer read data
buf_empty  in  1  buffer empty flag
m_data  out  DATA_W  output word
m_valid  out  1  output word valid
m_ready  in  1  consumer accept

Behaviour:
- Reset (async, Rst_n=0): state IDLE; all outputs 0; latched mode and length 0. buf_rd/buf_en drop immediately, including mid-operation. A word in flight is lost.
- FSM states: IDLE, CHECK, ISSUE, HOLD, DONE. All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE: on start=1, latch mode and clamped req_len, clear rd_count/short/timeout, set busy, go to CHECK.
- CHECK: sample buf_empty.
  - If 1: go to DONE. Set short=1 if req_len≠0 and rd_count<req_len.
  - If 0: go to ISSUE.
- ISSUE: buf_en=buf_rd=1 for exactly one cycle. The buffer updates its output on the falling edge inside this cycle. At the next rising edge capture buf_data into m_data, set m_valid=1, go to HOLD.
- HOLD: m_data is stable while m_valid=1 and m_ready=0. On m_valid&m_ready: m_valid<=0 and rd_count<=rd_count+1.
  - If req_len≠0 and rd_count+1==req_len: go to DONE.
  - Otherwise: go to CHECK.
- DONE: done=1 for one cycle, busy<=0, go to IDLE. rd_count, short and timeout hold until the next accepted start.
- Latency: start edge → buf_rd high 2 cycles later → m_valid high 3 cycles after start. Steady state with m_ready=1 is one word per 3 cycles.
- start while busy is ignored. start asserted in the same cycle as done is ignored.
- buf_mode stays stable while busy, so a mode change cannot corrupt the buffer mid-drain.
- rd_count saturates at DEPTH; wrap-around is impossible because of the clamp.

Optional Feature:
Macro BUFFER_READER_TIMEOUT_EN.
- Defined: a stall counter counts consecutive HOLD cycles with m_ready=0. When it reaches TIMEOUT_CYC, drop m_valid, discard the word without incrementing rd_count, set timeout=1 and go to DONE. The counter resets on any handshake or state exit.
- Undefined: HOLD waits indefinitely; timeout is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package: FSM state enum (IDLE, CHECK, ISSUE, HOLD, DONE), mode constants MODE_FIFO=0 and MODE_LIFO=1, default DATA_W/DEPTH.
- One natural sub-module: buffer_reader_out_reg, the output holding register with m_data/m_valid hold-under-backpressure logic. The FSM stays in the top.

Test Plan:
- FIFO mode, buffer preloaded 0x11,0x22,0x33, req_len=0, m_ready=1 → m_data 0x11,0x22,0x33 in order; done with short=0; rd_count=3; buf_rd never high while buf_empty=1.
- LIFO mode, buffer preloaded 0xA1,0xB2,0xC3, req_len=2 → two words delivered in stack order; done after 2; rd_count=2; one entry remains.
- FIFO, 2 entries, req_len=5 → 2 words delivered, then done with short=1 and rd_count=2.
- m_ready held low 10 cycles during HOLD → m_data/m_valid stable throughout, exactly one buf_rd pulse; word accepted when m_ready rises.
- Rst_n pulled low while in ISSUE → buf_rd/m_valid/busy go 0 immediately; start after release behaves normally.
- With BUFFER_READER_TIMEOUT_EN and TIMEOUT_CYC=16, m_ready=0 → at cycle 16 of HOLD, m_valid=0, done=1, timeout=1, rd_count unchanged.

Source files
------------

// File: rtl/buffer_reader_pkg.sv
// Shared types and defaults for the buffer read-side controller.
// Optional stall timeout is enabled with BUFFER_READER_TIMEOUT_EN.
package buffer_reader_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_CNT_W       = 4;
  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Bits needed to count 0..cyc inclusive.
  function automatic int unsigned stall_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/buffer_reader_out_reg.sv
// Output holding register: captures a buffer word and holds m_data/m_valid
// stable under backpressure until the consumer accepts or the word is dropped.
module buffer_reader_out_reg
  import buffer_reader_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drop,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              fire
);

  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;

  assign fire = m_valid_q & m_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (load) begin
      m_data_d  = load_data;
      m_valid_d = 1'b1;
    end else if (fire || drop) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: rtl/buffer_reader.sv
// Read-side controller that drains up to req_len entries from the FIFO/LIFO
// buffer onto a valid/ready stream. Define BUFFER_READER_TIMEOUT_EN for stall abort.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  req_len,
  output logic              busy,
  output logic              done,
  output logic              short,
  output logic              timeout,
  output logic [CNT_W-1:0]  rd_count,
  output logic              buf_en,
  output logic              buf_rd,
  output logic              buf_mode,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              buf_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  if (DEPTH >= (1 << CNT_W) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("buffer_reader: CNT_W cannot hold DEPTH, or TIMEOUT_CYC < 1");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic             timeout_q, timeout_d;
  logic             issue_q, issue_d;

  logic [CNT_W-1:0] len_clamped;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_word;
  logic             drop;
  logic             fire;

`ifdef BUFFER_READER_TIMEOUT_EN
  localparam int unsigned           STALL_W    = stall_width(TIMEOUT_CYC);
  localparam logic [STALL_W-1:0]    STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  logic            [STALL_W-1:0]    stall_q, stall_d;
`endif

  assign len_clamped = (req_len > DEPTH_C) ? DEPTH_C : req_len;
  // The clamp keeps cnt_q <= DEPTH, so saturation only guards against misuse.
  assign cnt_inc     = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CNT_W'(1);
  assign last_word   = (len_q != '0) && (cnt_inc == len_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    short_d   = short_q;
    timeout_d = timeout_q;
    issue_d   = 1'b0;
    drop      = 1'b0;
`ifdef BUFFER_READER_TIMEOUT_EN
    stall_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = (mode == MODE_LIFO) ? MODE_LIFO : MODE_FIFO;
          len_d     = len_clamped;
          cnt_d     = '0;
          short_d   = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (buf_empty) begin
          short_d = (len_q != '0) && (cnt_q < len_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          issue_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // The out register captures buf_data on the edge that leaves ISSUE.
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (fire) begin
          cnt_d = cnt_inc;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CHECK;
          end
        end
`ifdef BUFFER_READER_TIMEOUT_EN
        else if (stall_q == STALL_LAST) begin
          drop      = 1'b1;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_FIFO;
      len_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
      issue_q   <= 1'b0;
`ifdef BUFFER_READER_TIMEOUT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      short_q   <= short_d;
      timeout_q <= timeout_d;
      issue_q   <= issue_d;
`ifdef BUFFER_READER_TIMEOUT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  buffer_reader_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q == ST_ISSUE),
    .load_data (buf_data),
    .drop      (drop),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .fire      (fire)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign short    = short_q;
  assign timeout  = timeout_q;
  assign rd_count = cnt_q;
  assign buf_en   = issue_q;
  assign buf_rd   = issue_q;
  assign buf_mode = mode_q;

endmodule
